// File: rtl/led7seg_pkg.sv
// Shared constants and types for the multiplexed 4-digit 7-segment scanner.
package led7seg_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam logic [3:0]  AN_OFF   = 4'b1111;
  localparam logic [3:0]  BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_t;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/led7seg_prescaler.sv
// Free-running slot prescaler: cnt counts 0..DIV-1, tick marks the last cycle of a slot.
module led7seg_prescaler #(
  parameter  int unsigned DIV = 50000,
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led7seg_scan4.sv
// 4-digit common-anode scanner: double-buffered BCD capture, leading-zero/invalid blanking,
// anode dead-time at the start of each slot, registered num/an/dp outputs.
module led7seg_scan4
  import led7seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 2,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          tick;
  logic [CW-1:0] cnt;

  slot_e         idx_q;
  disp_t         disp_q;
  disp_t         pend_q;
  logic          pend_vld_q;
  logic [3:0]    num_q;
  logic [3:0]    an_q;
  logic          dp_q;
  logic          frame_done_q;

  logic          frame_end;
  logic [3:0]    blank;
  logic [3:0]    cur_nib;
  logic          an_on;
  logic [3:0]    num_d;
  logic [3:0]    an_d;
  logic          dp_d;

  led7seg_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .cnt  (cnt)
  );

  assign frame_end = tick && (idx_q == SLOT3);

  // A digit is a leading zero when it and every higher nibble are 0; its own dp request keeps it lit.
  always_comb begin
    blank = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      blank[i] = !is_bcd(disp_q.bcd[4*i +: 4]) ||
                 (BLANK_LZ && (i != 0) && !disp_q.dp[i] &&
                  ((disp_q.bcd >> (4*i)) == 16'h0000));
    end
  end

  assign cur_nib = disp_q.bcd[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_on = (cnt >= CW'(GUARD)) && !blank[idx_q];
    num_d = blank[idx_q] ? 4'd0 : cur_nib;
    an_d  = an_on ? ~(4'b0001 << idx_q) : AN_OFF;
    dp_d  = an_on ? ~disp_q.dp[idx_q] : 1'b1;
  end

  // frame_done is registered alongside num/an/dp so it lines up with the last output cycle of slot 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= SLOT0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      num_q        <= '0;
      an_q         <= AN_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      if (tick) begin
        idx_q <= slot_e'(idx_q + 2'd1);
      end

      if (frame_end) begin
        if (load) begin
          disp_q <= '{bcd: bcd_in, dp: dp_in};
        end else if (pend_vld_q) begin
          disp_q <= pend_q;
        end
        pend_vld_q <= 1'b0;
      end else if (load) begin
        pend_q     <= '{bcd: bcd_in, dp: dp_in};
        pend_vld_q <= 1'b1;
      end

      num_q        <= num_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_end;
    end
  end

  assign num        = num_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_scan4.sv
// Scoreboard bench for led7seg_scan4: a frame-level reference model predicts each cycle's outputs
// for a leading-zero-blanking instance and a show-all instance driven by the same stimulus.
module tb_led7seg_scan4;

  localparam int unsigned DIV   = 4;
  localparam int unsigned GRD   = 1;
  localparam int          FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] num;
    logic [3:0] an;
    logic       dp;
    logic       fd;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  num_a, an_a, num_b, an_b;
  logic        dp_a, fd_a, dp_b, fd_b;

  int n_checks = 0;
  int n_fail   = 0;

  led7seg_scan4 #(
    .SCAN_DIV (DIV),
    .GUARD    (GRD),
    .BLANK_LZ (1'b1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .num        (num_a),
    .an         (an_a),
    .dp         (dp_a),
    .frame_done (fd_a)
  );

  led7seg_scan4 #(
    .SCAN_DIV (DIV),
    .GUARD    (GRD),
    .BLANK_LZ (1'b0)
  ) u_dut_nolz (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .num        (num_b),
    .an         (an_b),
    .dp         (dp_b),
    .frame_done (fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: cycles since reset and the shown / pending display words.
  int          phase = 0;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_dp   = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_pdp  = '0;
  bit          m_pvld = 1'b0;
  exp_t        sb[$];

  function automatic out_t predict(input logic [15:0] v, input logic [3:0] dpv,
                                   input int slot, input int c, input bit blz);
    out_t       r;
    logic [3:0] nib;
    bit         blank;
    bit         on;
    nib   = v[4*slot +: 4];
    blank = (nib > 4'd9) || (blz && slot > 0 && !dpv[slot] && ((v >> (4*slot)) == 16'h0));
    on    = !blank && (c >= int'(GRD));
    r.num = blank ? 4'd0 : nib;
    r.an  = on ? ~(4'b0001 << slot) : 4'b1111;
    r.dp  = on ? ~dpv[slot] : 1'b1;
    r.fd  = (c == int'(DIV) - 1) && (slot == 3);
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   slot;
    int   c;
    if (rst) begin
      e.a    = '{num: 4'd0, an: 4'b1111, dp: 1'b1, fd: 1'b0};
      e.b    = e.a;
      phase  = 0;
      m_val  = '0;
      m_dp   = '0;
      m_pend = '0;
      m_pdp  = '0;
      m_pvld = 1'b0;
    end else begin
      slot = (phase / int'(DIV)) % 4;
      c    = phase % int'(DIV);
      e.a  = predict(m_val, m_dp, slot, c, 1'b1);
      e.b  = predict(m_val, m_dp, slot, c, 1'b0);
      if (e.a.fd) begin
        if (load) begin
          m_val = bcd_in;
          m_dp  = dp_in;
        end else if (m_pvld) begin
          m_val = m_pend;
          m_dp  = m_pdp;
        end
        m_pvld = 1'b0;
      end else if (load) begin
        m_pend = bcd_in;
        m_pdp  = dp_in;
        m_pvld = 1'b1;
      end
      phase++;
    end
    sb.push_back(e);
  end

  task automatic chk(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got num=%h an=%b dp=%b fd=%b want num=%h an=%b dp=%b fd=%b",
               name, $time, act.num, act.an, act.dp, act.fd, exp.num, exp.an, exp.dp, exp.fd);
    end
  endtask

  task automatic chk_rule(input string name, input bit ok, input logic [3:0] an_v, input logic dp_v);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t got an=%b dp=%b", name, $time, an_v, dp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_lz",   '{num: num_a, an: an_a, dp: dp_a, fd: fd_a}, e.a);
      chk("out_nolz", '{num: num_b, an: an_b, dp: dp_b, fd: fd_b}, e.b);
      chk_rule("onehot_an_lz",   $onehot0(~an_a), an_a, dp_a);
      chk_rule("onehot_an_nolz", $onehot0(~an_b), an_b, dp_b);
      chk_rule("dp_off_lz",   (an_a != 4'b1111) || (dp_a == 1'b1), an_a, dp_a);
      chk_rule("dp_off_nolz", (an_b != 4'b1111) || (dp_b == 1'b1), an_b, dp_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits until the next posedge will see the given cycle offset within the frame.
  task automatic wait_phase(input int t);
    int k;
    k = 0;
    while (((phase % FRAME) != t) && (k < 4 * FRAME)) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if ((phase % FRAME) != t) begin
      n_fail++;
      $display("FAIL wait_phase got=%0d want=%0d", phase % FRAME, t);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load   = 1'b1;
    bcd_in = v;
    dp_in  = d;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  d;
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    step(3);
    rst = 1'b0;
    step(2 * FRAME);

    wait_phase(3);
    do_load(16'h1234, 4'b0000);
    step(2 * FRAME + 5);

    wait_phase(2);
    do_load(16'h0050, 4'b0000);
    step(2 * FRAME + 3);

    do_load(16'h12A4, 4'b0100);
    step(2 * FRAME);

    wait_phase(4);
    do_load(16'h1111, 4'b0000);
    wait_phase(9);
    do_load(16'h2222, 4'b0001);
    wait_phase(FRAME - 1);
    do_load(16'h3333, 4'b0000);
    wait_phase(5);
    do_load(16'h4444, 4'b0000);
    step(2 * FRAME);

    do_load(16'h0005, 4'b1000);
    step(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    step(2 * FRAME);

    wait_phase(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2 * FRAME);

    for (int i = 0; i < 80; i++) begin
      v = 16'($urandom);
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 2) == 0) v[4*j +: 4] = 4'd0;
        else if ($urandom_range(0, 4) != 0) v[4*j +: 4] = 4'($urandom_range(0, 9));
      end
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step($urandom_range(1, 20));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      do_load(v, d);
    end
    step(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
